multicycle_control: RTL and testbench
=====================================

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 The block SHALL have exactly one clock and one reset; reset SHALL be synchronous and active-high.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous active-high reset.
REQ-004 opcode  input  6  instruction[31:26] from the instruction register.
REQ-005 zero  input  1  ALU zero flag, same cycle.
REQ-006 mem_ready  input  1  memory handshake; access completes in the cycle it is 1.
REQ-007 pc_we  output  1  PC write enable.
REQ-008 pc_src  output  2  00 ALU result, 01 ALUOut (branch target), 10 jump target.
REQ-009 ir_we  output  1  instruction register write enable.
REQ-010 mem_read, mem_write  output  1 each  memory strobes.
REQ-011 iord  output  1  memory address select: 0 PC, 1 ALUOut.
REQ-012 reg_write, reg_dst, mem_to_reg  output  1 each  register-file controls (reg_dst 1 = rd).
REQ-013 alu_src_a  output  1  0 PC, 1 register A.
REQ-014 alu_src_b  output  2  00 register B, 01 constant 4, 10 extended imm, 11 extended imm<<2.
REQ-015 alu_op  output  2  00 add, 01 subtract, 10 funct decode, 11 xor.
REQ-016 sign_zero  output  1  0 sign-extend, 1 zero-extend immediate.
REQ-017 state  output  4  current state encoding (debug).
REQ-018 illegal  output  1  trap flag (see Configuration).

Function
REQ-019 Outputs SHALL decode combinationally from state; every output not listed for a state SHALL be 0.
REQ-020 States/encodings: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXEC 6, ALUWB 7, BRANCH 8, JUMP 9, IEXEC 10, IWB 11, TRAP 12; encodings 13-15 SHALL go to FETCH.
REQ-021 FETCH: mem_read=1, iord=0, alu_src_b=01, alu_op=00; ir_we=pc_we=mem_ready, pc_src=00; stays until mem_ready=1, then DECODE.
REQ-022 DECODE: alu_src_b=11, alu_op=00; next: 000000 EXEC, 100011/101011 MEMADR, 000101 BRANCH, 000010 JUMP, 001110 IEXEC, other per REQ-034.
REQ-023 MEMADR: alu_src_a=1, alu_src_b=10, alu_op=00; next MEMRD for 100011, MEMWR for 101011.
REQ-024 MEMRD: mem_read=1, iord=1; holds until mem_ready=1, then MEMWB.
REQ-025 MEMWB: reg_write=1, mem_to_reg=1, reg_dst=0; next FETCH.
REQ-026 MEMWR: mem_write=1, iord=1; holds until mem_ready=1, then FETCH; mem_write held stable while waiting.
REQ-027 EXEC: alu_src_a=1, alu_src_b=00, alu_op=10; next ALUWB (reg_write=1, reg_dst=1) then FETCH.
REQ-028 BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_src=01, pc_we=~zero; next FETCH.
REQ-029 JUMP: pc_we=1, pc_src=10; next FETCH.
REQ-030 IEXEC: alu_src_a=1, alu_src_b=10, alu_op=11, sign_zero=1; next IWB (reg_write=1, reg_dst=0, sign_zero=1) then FETCH.
REQ-031 Zero-wait latency in cycles FETCH to FETCH: R-type 4, lw 5, sw 4, bne 3, j 3, xori 4; each mem_ready=0 cycle adds one.
REQ-032 At most one of mem_read/mem_write SHALL be 1 in any cycle.

Reset
REQ-033 reset=1 at a rising edge SHALL load FETCH regardless of state or mem_ready, aborting any pending access; while reset=1, pc_we, ir_we, reg_write, mem_write SHALL be forced 0 and illegal cleared.

Configuration
REQ-034 Macro MC_ILLEGAL_TRAP_EN: defined -> unlisted opcode in DECODE goes to TRAP, illegal=1, held until reset, no strobes; undefined -> unlisted opcode returns to FETCH (NOP), TRAP unreachable, illegal tied 0.

Verification
REQ-035 reset then mem_ready=1, opcode=000000 -> states 0,1,6,7,0; reg_write=1, reg_dst=1 only in state 7.
REQ-036 opcode=100011, mem_ready=0 for 2 cycles in MEMRD -> states 0,1,2,3,3,3,4,0; mem_read, iord held 1 in state 3.
REQ-037 opcode=000101 with zero=0 then zero=1 -> pc_we=1,pc_src=01 in BRANCH first pass; pc_we=0 second pass.
REQ-038 opcode=001110 -> states 0,1,10,11,0; alu_op=11, sign_zero=1 in 10 and 11.
REQ-039 reset asserted in MEMWR with mem_ready=0 -> FETCH next cycle; mem_write=0 in reset cycle.
REQ-040 opcode=111111: with MC_ILLEGAL_TRAP_EN -> state 12, illegal=1 until reset; without -> states 0,1,0, illegal=0.

Source files
------------

// File: rtl/multicycle_control_if.sv
// Control-bus bundle between the multicycle datapath (master) and its
// control FSM (slave). Datapath drives opcode/flags, controller drives strobes.
interface multicycle_control_if;
  logic [5:0] opcode;
  logic       zero;
  logic       mem_ready;
  logic       pc_we;
  logic [1:0] pc_src;
  logic       ir_we;
  logic       mem_read;
  logic       mem_write;
  logic       iord;
  logic       reg_write;
  logic       reg_dst;
  logic       mem_to_reg;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic       sign_zero;
  logic [3:0] state;
  logic       illegal;

  modport master (
    output opcode, zero, mem_ready,
    input  pc_we, pc_src, ir_we, mem_read, mem_write, iord, reg_write, reg_dst,
           mem_to_reg, alu_src_a, alu_src_b, alu_op, sign_zero, state, illegal
  );

  modport slave (
    input  opcode, zero, mem_ready,
    output pc_we, pc_src, ir_we, mem_read, mem_write, iord, reg_write, reg_dst,
           mem_to_reg, alu_src_a, alu_src_b, alu_op, sign_zero, state, illegal
  );
endinterface

// File: rtl/multicycle_control.sv
// Multicycle MIPS-style control FSM; outputs are a pure decode of state.
// Optional macro MC_ILLEGAL_TRAP_EN: unlisted opcodes park in TRAP with illegal=1.
module multicycle_control (
  input  logic                 clk,
  input  logic                 reset,
  multicycle_control_if.slave  bus
);
  localparam logic [3:0] S_FETCH  = 4'd0;
  localparam logic [3:0] S_DECODE = 4'd1;
  localparam logic [3:0] S_MEMADR = 4'd2;
  localparam logic [3:0] S_MEMRD  = 4'd3;
  localparam logic [3:0] S_MEMWB  = 4'd4;
  localparam logic [3:0] S_MEMWR  = 4'd5;
  localparam logic [3:0] S_EXEC   = 4'd6;
  localparam logic [3:0] S_ALUWB  = 4'd7;
  localparam logic [3:0] S_BRANCH = 4'd8;
  localparam logic [3:0] S_JUMP   = 4'd9;
  localparam logic [3:0] S_IEXEC  = 4'd10;
  localparam logic [3:0] S_IWB    = 4'd11;
  localparam logic [3:0] S_TRAP   = 4'd12;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_XORI  = 6'b001110;

  logic [3:0] r_state;
  logic [3:0] w_next;

  always_comb begin
    w_next = S_FETCH;
    case (r_state)
      S_FETCH:  w_next = bus.mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (bus.opcode)
          OP_RTYPE:      w_next = S_EXEC;
          OP_LW, OP_SW:  w_next = S_MEMADR;
          OP_BNE:        w_next = S_BRANCH;
          OP_J:          w_next = S_JUMP;
          OP_XORI:       w_next = S_IEXEC;
`ifdef MC_ILLEGAL_TRAP_EN
          default:       w_next = S_TRAP;
`else
          default:       w_next = S_FETCH;
`endif
        endcase
      end
      S_MEMADR: begin
        if (bus.opcode == OP_LW)      w_next = S_MEMRD;
        else if (bus.opcode == OP_SW) w_next = S_MEMWR;
        else                          w_next = S_FETCH;
      end
      S_MEMRD:  w_next = bus.mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWR:  w_next = bus.mem_ready ? S_FETCH : S_MEMWR;
      S_EXEC:   w_next = S_ALUWB;
      S_IEXEC:  w_next = S_IWB;
`ifdef MC_ILLEGAL_TRAP_EN
      S_TRAP:   w_next = S_TRAP;
`else
      S_TRAP:   w_next = S_FETCH;
`endif
      default:  w_next = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_FETCH;
    else       r_state <= w_next;
  end

  logic       w_pc_we, w_ir_we, w_mem_read, w_mem_write, w_iord;
  logic       w_reg_write, w_reg_dst, w_mem_to_reg, w_alu_src_a, w_sign_zero;
  logic [1:0] w_pc_src, w_alu_src_b, w_alu_op;

  always_comb begin
    w_pc_we      = 1'b0;
    w_pc_src     = 2'b00;
    w_ir_we      = 1'b0;
    w_mem_read   = 1'b0;
    w_mem_write  = 1'b0;
    w_iord       = 1'b0;
    w_reg_write  = 1'b0;
    w_reg_dst    = 1'b0;
    w_mem_to_reg = 1'b0;
    w_alu_src_a  = 1'b0;
    w_alu_src_b  = 2'b00;
    w_alu_op     = 2'b00;
    w_sign_zero  = 1'b0;
    case (r_state)
      S_FETCH: begin
        w_mem_read  = 1'b1;
        w_alu_src_b = 2'b01;
        w_ir_we     = bus.mem_ready;
        w_pc_we     = bus.mem_ready;
      end
      S_DECODE: w_alu_src_b = 2'b11;
      S_MEMADR: begin
        w_alu_src_a = 1'b1;
        w_alu_src_b = 2'b10;
      end
      S_MEMRD: begin
        w_mem_read = 1'b1;
        w_iord     = 1'b1;
      end
      S_MEMWB: begin
        w_reg_write  = 1'b1;
        w_mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        w_mem_write = 1'b1;
        w_iord      = 1'b1;
      end
      S_EXEC: begin
        w_alu_src_a = 1'b1;
        w_alu_op    = 2'b10;
      end
      S_ALUWB: begin
        w_reg_write = 1'b1;
        w_reg_dst   = 1'b1;
      end
      // bne: write PC with the branch target only when operands differ
      S_BRANCH: begin
        w_alu_src_a = 1'b1;
        w_alu_op    = 2'b01;
        w_pc_src    = 2'b01;
        w_pc_we     = ~bus.zero;
      end
      S_JUMP: begin
        w_pc_we  = 1'b1;
        w_pc_src = 2'b10;
      end
      S_IEXEC: begin
        w_alu_src_a = 1'b1;
        w_alu_src_b = 2'b10;
        w_alu_op    = 2'b11;
        w_sign_zero = 1'b1;
      end
      S_IWB: begin
        w_reg_write = 1'b1;
        w_sign_zero = 1'b1;
      end
      default: ;
    endcase
  end

  // Architectural write strobes are masked during reset so an aborted access
  // cannot corrupt PC, IR, register file or memory.
  assign bus.pc_we      = w_pc_we & ~reset;
  assign bus.ir_we      = w_ir_we & ~reset;
  assign bus.reg_write  = w_reg_write & ~reset;
  assign bus.mem_write  = w_mem_write & ~reset;
  assign bus.pc_src     = w_pc_src;
  assign bus.mem_read   = w_mem_read;
  assign bus.iord       = w_iord;
  assign bus.reg_dst    = w_reg_dst;
  assign bus.mem_to_reg = w_mem_to_reg;
  assign bus.alu_src_a  = w_alu_src_a;
  assign bus.alu_src_b  = w_alu_src_b;
  assign bus.alu_op     = w_alu_op;
  assign bus.sign_zero  = w_sign_zero;
  assign bus.state      = r_state;
`ifdef MC_ILLEGAL_TRAP_EN
  assign bus.illegal    = (r_state == S_TRAP) & ~reset;
`else
  assign bus.illegal    = 1'b0;
`endif
endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: each cycle pushes the expected
// state/control word, then pops and compares it mid-cycle.
module tb_multicycle_control;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  multicycle_control_if bus();
  multicycle_control dut (.clk(clk), .reset(reset), .bus(bus));

  typedef struct packed {
    logic [3:0]  st;
    logic [16:0] ctl;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  wire [16:0] w_ctl = {bus.pc_we, bus.pc_src, bus.ir_we, bus.mem_read, bus.mem_write,
                       bus.iord, bus.reg_write, bus.reg_dst, bus.mem_to_reg,
                       bus.alu_src_a, bus.alu_src_b, bus.alu_op, bus.sign_zero, bus.illegal};

  function automatic logic [16:0] exp_ctl(logic [3:0] st, logic mr, logic z, logic rst);
    logic pw = 0, irw = 0, mrd = 0, mwr = 0, io = 0, rw = 0, rd = 0, m2r = 0, sa = 0, sz = 0, il = 0;
    logic [1:0] ps = 0, sb = 0, op = 0;
    case (st)
      4'd0:  begin mrd = 1; sb = 2'b01; irw = mr; pw = mr; end
      4'd1:  sb = 2'b11;
      4'd2:  begin sa = 1; sb = 2'b10; end
      4'd3:  begin mrd = 1; io = 1; end
      4'd4:  begin rw = 1; m2r = 1; end
      4'd5:  begin mwr = 1; io = 1; end
      4'd6:  begin sa = 1; op = 2'b10; end
      4'd7:  begin rw = 1; rd = 1; end
      4'd8:  begin sa = 1; op = 2'b01; ps = 2'b01; pw = ~z; end
      4'd9:  begin pw = 1; ps = 2'b10; end
      4'd10: begin sa = 1; sb = 2'b10; op = 2'b11; sz = 1; end
      4'd11: begin rw = 1; sz = 1; end
`ifdef MC_ILLEGAL_TRAP_EN
      4'd12: il = 1;
`endif
      default: ;
    endcase
    if (rst) begin pw = 0; irw = 0; rw = 0; mwr = 0; il = 0; end
    return {pw, ps, irw, mrd, mwr, io, rw, rd, m2r, sa, sb, op, sz, il};
  endfunction

  // Drive one cycle of inputs just after the edge and queue what the DUT must show.
  task automatic drive(input logic mr, input logic z, input logic rst, input logic [3:0] st);
    @(posedge clk); #1;
    bus.mem_ready = mr;
    bus.zero      = z;
    reset         = rst;
    q.push_back('{st: st, ctl: exp_ctl(st, mr, z, rst)});
  endtask

  task automatic test_reset();
    exp_t e;
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 1'b0, 1'b1, 4'd0);
      @(negedge clk);
      e = q.pop_front(); n_tests++;
      if ({bus.pc_we, bus.ir_we, bus.reg_write, bus.mem_write, bus.illegal} !== 5'b0) begin
        n_fail++;
        $display("FAIL reset_strobes cyc%0d got=%b want=00000", i,
                 {bus.pc_we, bus.ir_we, bus.reg_write, bus.mem_write, bus.illegal});
      end
    end
    drive(1'b0, 1'b0, 1'b0, 4'd0);
    @(negedge clk);
    e = q.pop_front(); n_tests++;
    if (bus.state !== e.st || w_ctl !== e.ctl) begin
      n_fail++;
      $display("FAIL reset_state got st=%0d ctl=%h want st=%0d ctl=%h", bus.state, w_ctl, e.st, e.ctl);
    end
  endtask

  task automatic test_rtype();
    logic [3:0] st [5] = '{0, 1, 6, 7, 0};
    logic       mr [5] = '{1, 1, 1, 1, 0};
    exp_t e;
    bus.opcode = 6'b000000;
    for (int i = 0; i < 5; i++) begin
      drive(mr[i], 1'b0, 1'b0, st[i]);
      @(negedge clk);
      e = q.pop_front(); n_tests++;
      if (bus.state !== e.st || w_ctl !== e.ctl) begin
        n_fail++;
        $display("FAIL rtype cyc%0d got st=%0d ctl=%h want st=%0d ctl=%h", i, bus.state, w_ctl, e.st, e.ctl);
      end
    end
  endtask

  task automatic test_lw_stall();
    logic [3:0] st [8] = '{0, 1, 2, 3, 3, 3, 4, 0};
    logic       mr [8] = '{1, 1, 1, 0, 0, 1, 1, 0};
    exp_t e;
    bus.opcode = 6'b100011;
    for (int i = 0; i < 8; i++) begin
      drive(mr[i], 1'b0, 1'b0, st[i]);
      @(negedge clk);
      e = q.pop_front(); n_tests++;
      if (bus.state !== e.st || w_ctl !== e.ctl) begin
        n_fail++;
        $display("FAIL lw_stall cyc%0d got st=%0d ctl=%h want st=%0d ctl=%h", i, bus.state, w_ctl, e.st, e.ctl);
      end
    end
  endtask

  task automatic test_sw_fetch_stall();
    logic [3:0] st [7] = '{0, 0, 1, 2, 5, 5, 0};
    logic       mr [7] = '{0, 1, 1, 1, 0, 1, 0};
    exp_t e;
    bus.opcode = 6'b101011;
    for (int i = 0; i < 7; i++) begin
      drive(mr[i], 1'b0, 1'b0, st[i]);
      @(negedge clk);
      e = q.pop_front(); n_tests++;
      if (bus.state !== e.st || w_ctl !== e.ctl || (bus.mem_read & bus.mem_write) !== 1'b0) begin
        n_fail++;
        $display("FAIL sw_stall cyc%0d got st=%0d ctl=%h want st=%0d ctl=%h", i, bus.state, w_ctl, e.st, e.ctl);
      end
    end
  endtask

  task automatic test_branch();
    logic [3:0] st [4] = '{0, 1, 8, 0};
    logic       mr [4] = '{1, 1, 1, 0};
    exp_t e;
    bus.opcode = 6'b000101;
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < 4; i++) begin
        drive(mr[i], p[0], 1'b0, st[i]);
        @(negedge clk);
        e = q.pop_front(); n_tests++;
        if (bus.state !== e.st || w_ctl !== e.ctl) begin
          n_fail++;
          $display("FAIL branch z=%0d cyc%0d got st=%0d ctl=%h want st=%0d ctl=%h", p, i, bus.state, w_ctl, e.st, e.ctl);
        end
      end
    end
  endtask

  task automatic test_jump();
    logic [3:0] st [4] = '{0, 1, 9, 0};
    logic       mr [4] = '{1, 1, 1, 0};
    exp_t e;
    bus.opcode = 6'b000010;
    for (int i = 0; i < 4; i++) begin
      drive(mr[i], 1'b1, 1'b0, st[i]);
      @(negedge clk);
      e = q.pop_front(); n_tests++;
      if (bus.state !== e.st || w_ctl !== e.ctl) begin
        n_fail++;
        $display("FAIL jump cyc%0d got st=%0d ctl=%h want st=%0d ctl=%h", i, bus.state, w_ctl, e.st, e.ctl);
      end
    end
  endtask

  task automatic test_xori();
    logic [3:0] st [5] = '{0, 1, 10, 11, 0};
    logic       mr [5] = '{1, 1, 1, 1, 0};
    exp_t e;
    bus.opcode = 6'b001110;
    for (int i = 0; i < 5; i++) begin
      drive(mr[i], 1'b0, 1'b0, st[i]);
      @(negedge clk);
      e = q.pop_front(); n_tests++;
      if (bus.state !== e.st || w_ctl !== e.ctl) begin
        n_fail++;
        $display("FAIL xori cyc%0d got st=%0d ctl=%h want st=%0d ctl=%h", i, bus.state, w_ctl, e.st, e.ctl);
      end
    end
  endtask

  task automatic test_reset_in_memwr();
    logic [3:0] st  [6] = '{0, 1, 2, 5, 5, 0};
    logic       mr  [6] = '{1, 1, 1, 0, 0, 0};
    logic       rst [6] = '{0, 0, 0, 0, 1, 0};
    exp_t e;
    bus.opcode = 6'b101011;
    for (int i = 0; i < 6; i++) begin
      drive(mr[i], 1'b0, rst[i], st[i]);
      @(negedge clk);
      e = q.pop_front(); n_tests++;
      if (bus.state !== e.st || w_ctl !== e.ctl) begin
        n_fail++;
        $display("FAIL reset_memwr cyc%0d got st=%0d ctl=%h want st=%0d ctl=%h", i, bus.state, w_ctl, e.st, e.ctl);
      end
    end
  endtask

  task automatic test_illegal();
`ifdef MC_ILLEGAL_TRAP_EN
    logic [3:0] st  [7] = '{0, 1, 12, 12, 12, 12, 0};
    logic       mr  [7] = '{1, 1, 1, 0, 1, 1, 0};
    logic       rst [7] = '{0, 0, 0, 0, 0, 1, 0};
    localparam int N = 7;
`else
    logic [3:0] st  [4] = '{0, 1, 0, 0};
    logic       mr  [4] = '{1, 1, 0, 0};
    logic       rst [4] = '{0, 0, 0, 0};
    localparam int N = 4;
`endif
    exp_t e;
    bus.opcode = 6'b111111;
    for (int i = 0; i < N; i++) begin
      drive(mr[i], 1'b0, rst[i], st[i]);
      @(negedge clk);
      e = q.pop_front(); n_tests++;
      if (bus.state !== e.st || w_ctl !== e.ctl) begin
        n_fail++;
        $display("FAIL illegal cyc%0d got st=%0d ctl=%h want st=%0d ctl=%h", i, bus.state, w_ctl, e.st, e.ctl);
      end
    end
  endtask

  initial begin
    bus.opcode    = 6'b000000;
    bus.zero      = 1'b0;
    bus.mem_ready = 1'b0;
    test_reset();
    test_rtype();
    test_lw_stall();
    test_sw_fetch_stall();
    test_branch();
    test_jump();
    test_xori();
    test_reset_in_memwr();
    test_illegal();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
